// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer behind a UART receiver: byte FIFO with sticky overflow
// and a one-shot idle-gap pulse once the line goes quiet after traffic.
module uart_rx_fifo #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned IDLE_CYCLES = 4340
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_data_valid,
    input  logic [DATA_BITS-1:0]         i_data,
    output logic                         o_data_valid,
    input  logic                         i_data_ready,
    output logic [DATA_BITS-1:0]         o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_overflow,
    input  logic                         i_clear_overflow,
    output logic                         o_idle_timeout
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES);

    // The pulse is registered, so the decision is taken one cycle early: the counter
    // would reach IDLE_CYCLES-1 in the cycle the pulse is visible.
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 2);

    typedef enum logic [0:0] {
        StIdle,
        StArmed
    } idle_state_e;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic                 data_valid;
    logic                 overflow;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 drop;

    idle_state_e          idle_state;
    logic [IDLE_W-1:0]    idle_cnt;
    logic                 idle_pulse;

    always_comb begin
        full       = (count == CNT_W'(DEPTH));
        pop        = data_valid && i_data_ready;
        push       = i_data_valid && (!full || pop);
        drop       = i_data_valid && full && !pop;
        count_next = count + CNT_W'(push) - CNT_W'(pop);
    end

    // Storage carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count      <= count_next;
            data_valid <= (count_next != '0);
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (i_clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_state <= StIdle;
            idle_cnt   <= '0;
            idle_pulse <= 1'b0;
        end else begin
            idle_pulse <= 1'b0;
            if (i_data_valid) begin
                idle_state <= StArmed;
                idle_cnt   <= '0;
            end else begin
                unique case (idle_state)
                    StArmed: begin
                        if (idle_cnt == IDLE_LAST) begin
                            idle_pulse <= 1'b1;
                            idle_state <= StIdle;
                            idle_cnt   <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end
                    default: begin
                        idle_cnt <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        o_data_valid   = data_valid;
        o_data         = mem[rd_ptr];
        o_count        = count;
        o_overflow     = overflow;
        o_idle_timeout = idle_pulse;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table for FIFO basics plus
// directed sequences for overflow, full push/pop, idle timing and reset.
module tb_uart_rx_fifo;

    localparam int DATA_BITS   = 8;
    localparam int DEPTH       = 16;
    localparam int IDLE_CYCLES = 16;
    localparam int CW          = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_data_valid;
    logic [DATA_BITS-1:0] i_data;
    logic                 o_data_valid;
    logic                 i_data_ready;
    logic [DATA_BITS-1:0] o_data;
    logic [CW-1:0]        o_count;
    logic                 o_overflow;
    logic                 i_clear_overflow;
    logic                 o_idle_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DATA_BITS  (DATA_BITS),
        .DEPTH      (DEPTH),
        .IDLE_CYCLES(IDLE_CYCLES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_data_valid    (i_data_valid),
        .i_data          (i_data),
        .o_data_valid    (o_data_valid),
        .i_data_ready    (i_data_ready),
        .o_data          (o_data),
        .o_count         (o_count),
        .o_overflow      (o_overflow),
        .i_clear_overflow(i_clear_overflow),
        .o_idle_timeout  (o_idle_timeout)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       c;
        logic       ev;
        logic [7:0] ed;
        int         ec;
        logic       eo;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
        i_data_valid     = v;
        i_data           = d;
        i_data_ready     = r;
        i_clear_overflow = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst              = 1'b0;
        i_data_valid     = 1'b0;
        i_data           = '0;
        i_data_ready     = 1'b0;
        i_clear_overflow = 1'b0;

        //            v     d      r     c     ev    ed     ec  eo
        vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 8'h41, 1, 1'b0};
        vecs[1]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 8'h41, 2, 1'b0};
        vecs[2]  = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b1, 8'h41, 3, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 3, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h42, 2, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h43, 1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0};
        vecs[8]  = '{1'b1, 8'h50, 1'b1, 1'b0, 1'b1, 8'h50, 1, 1'b0};
        vecs[9]  = '{1'b1, 8'h51, 1'b1, 1'b0, 1'b1, 8'h51, 1, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};

        @(posedge clk);
        #1;
        do_reset();
        check("reset_valid", o_data_valid, 0);
        check("reset_count", o_count, 0);
        check("reset_overflow", o_overflow, 0);
        check("reset_idle", o_idle_timeout, 0);

        // Basic FWFT, empty-ready, and push/pop at occupancy one.
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c);
            check($sformatf("vec%0d_valid", i), o_data_valid, vecs[i].ev);
            check($sformatf("vec%0d_count", i), o_count, vecs[i].ec);
            check($sformatf("vec%0d_overflow", i), o_overflow, vecs[i].eo);
            if (vecs[i].ev) check($sformatf("vec%0d_data", i), o_data, vecs[i].ed);
        end

        // Overflow: 17 bytes into 16 entries, last one dropped.
        for (int i = 0; i <= DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            check($sformatf("ovf_fill%0d_count", i), o_count, (i < DEPTH) ? i + 1 : DEPTH);
            check($sformatf("ovf_fill%0d_flag", i), o_overflow, (i == DEPTH) ? 1 : 0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("ovf_drain%0d_data", i), o_data, i);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("ovf_drain_empty", o_data_valid, 0);
        check("ovf_flag_sticky", o_overflow, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_cleared", o_overflow, 0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check("full_count", o_count, DEPTH);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        check("full_pp_count", o_count, DEPTH);
        check("full_pp_overflow", o_overflow, 0);
        for (int i = 1; i <= DEPTH; i++) begin
            check($sformatf("full_pp_drain%0d", i), o_data, (i == DEPTH) ? 8'hAA : i);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("full_pp_empty", o_count, 0);

        // Clear colliding with a drop: set wins.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        check("collide_pre", o_overflow, 1);
        step(1'b1, 8'hEF, 1'b0, 1'b1);
        check("collide_set_wins", o_overflow, 1);
        check("collide_count", o_count, DEPTH);
        check("collide_head", o_data, 8'h00);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("collide_clear", o_overflow, 0);

        // Idle timing: no pulse after reset, one pulse IDLE_CYCLES after a lone byte.
        do_reset();
        for (int k = 0; k < 2 * IDLE_CYCLES; k++) begin
            check($sformatf("idle_post_reset%0d", k), o_idle_timeout, 0);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        step(1'b1, 8'h11, 1'b1, 1'b0);
        for (int k = 1; k <= 4 * IDLE_CYCLES; k++) begin
            check($sformatf("idle_single_k%0d", k), o_idle_timeout, (k == IDLE_CYCLES) ? 1 : 0);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Second byte in the would-be timeout cycle suppresses and restarts.
        step(1'b1, 8'h22, 1'b1, 1'b0);
        for (int k = 1; k <= 3 * IDLE_CYCLES; k++) begin
            check($sformatf("idle_restart_k%0d", k), o_idle_timeout,
                  (k == 2 * IDLE_CYCLES - 1) ? 1 : 0);
            step(k == IDLE_CYCLES - 1, 8'h33, 1'b1, 1'b0);
        end

        // Reset mid-operation with data stored and detector armed.
        for (int i = 0; i < 5; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        check("midrst_pre_count", o_count, 5);
        do_reset();
        check("midrst_count", o_count, 0);
        check("midrst_valid", o_data_valid, 0);
        check("midrst_overflow", o_overflow, 0);
        for (int k = 0; k < 3 * IDLE_CYCLES; k++) begin
            check($sformatf("midrst_idle%0d", k), o_idle_timeout, 0);
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        step(1'b1, 8'h55, 1'b0, 1'b0);
        check("midrst_push_valid", o_data_valid, 1);
        check("midrst_push_data", o_data, 8'h55);
        check("midrst_push_count", o_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
